// File: rtl/fpga_cfg_pkg.sv
// Shared types and CRC helper for the fabric configuration loader.
package fpga_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } cfg_state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // One bit of CRC-8, MSB-first, no reflection.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 accumulator with synchronous clear.
module crc8_serial
    import fpga_cfg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= 8'h00;
        end else if (clr) begin
            value <= 8'h00;
        end else if (en) begin
            value <= crc8_step(value, bit_in);
        end
    end

endmodule

// File: rtl/bitstream_loader.sv
// Streams configuration bytes MSB-first into the fabric chain and optionally
// recirculates the chain once to confirm its contents by CRC.
module bitstream_loader
    import fpga_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       verify_en,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       prog_en,
    output logic       prog_in,
    input  logic       prog_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] crc
);

    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int NBYTES = CHAIN_LEN / 8;
    localparam int BYTE_W = $clog2(NBYTES + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [BYTE_W-1:0] BYTES_MAX = BYTE_W'(NBYTES);

    cfg_state_t        state, state_nxt;
    logic [7:0]        shreg;
    logic [2:0]        sh_idx;
    logic [CNT_W-1:0]  bit_cnt;
    logic [BYTE_W-1:0] byte_cnt;
    logic              verify_q;
    logic [7:0]        lcrc, vcrc;

    logic start_ok, accept, load_shift, verify_shift, enter_done;

    assign start_ok     = start && (state == IDLE || state == DONE);
    assign load_shift   = (state == LOAD) && prog_en;
    assign verify_shift = (state == VERIFY) && prog_en;
    assign in_ready     = (state == LOAD) && (!prog_en || sh_idx == 3'd7)
                          && (byte_cnt < BYTES_MAX);
    assign accept       = in_valid && in_ready;
    // During VERIFY the chain is closed into a loop through this module.
    assign prog_in      = (state == VERIFY) ? prog_out : shreg[7];
    assign busy         = (state == LOAD) || (state == VERIFY);
    assign crc          = lcrc;
    assign enter_done   = (state != DONE) && (state_nxt == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = LOAD;
            LOAD:       if (load_shift && bit_cnt == LAST_BIT)
                            state_nxt = verify_q ? VERIFY : DONE;
            VERIFY:     if (verify_shift && bit_cnt == LAST_BIT) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_en  <= 1'b0;
            shreg    <= 8'h00;
            sh_idx   <= 3'd0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            verify_q <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            done <= enter_done;
            if (start_ok) begin
                prog_en  <= 1'b0;
                shreg    <= 8'h00;
                sh_idx   <= 3'd0;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                verify_q <= verify_en;
                pass     <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        if (load_shift)
                            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
                        // A byte taken on the last-bit cycle keeps the chain running gap-free.
                        if (accept) begin
                            shreg    <= in_data;
                            sh_idx   <= 3'd0;
                            prog_en  <= 1'b1;
                            byte_cnt <= byte_cnt + 1'b1;
                        end else if (load_shift && sh_idx != 3'd7) begin
                            shreg  <= {shreg[6:0], 1'b0};
                            sh_idx <= sh_idx + 3'd1;
                        end else begin
                            prog_en <= 1'b0;
                        end
                        if (load_shift && bit_cnt == LAST_BIT && verify_q)
                            prog_en <= 1'b1;
                    end
                    VERIFY: begin
                        if (verify_shift) begin
                            if (bit_cnt == LAST_BIT) begin
                                prog_en <= 1'b0;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
                // The final returned bit is folded in here since vcrc only absorbs it at this edge.
                if (enter_done)
                    pass <= verify_q ? (crc8_step(vcrc, prog_out) == lcrc) : 1'b1;
            end
        end
    end

    crc8_serial u_load_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (start_ok),
        .en     (load_shift),
        .bit_in (shreg[7]),
        .value  (lcrc)
    );

    crc8_serial u_verify_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (start_ok),
        .en     (verify_shift),
        .bit_in (prog_out),
        .value  (vcrc)
    );

endmodule

// File: tb/tb_bitstream_loader.sv
// Bench for bitstream_loader: 16-bit and 64-bit chain instances with chain models.
module tb_bitstream_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic       s_start, s_ven, s_valid, s_ready, s_pen, s_pin, s_pout, s_busy, s_done, s_pass;
    logic [7:0] s_data, s_crc;
    logic       l_start, l_ven, l_valid, l_ready, l_pen, l_pin, l_pout, l_busy, l_done, l_pass;
    logic [7:0] l_data, l_crc;

    bitstream_loader #(.CHAIN_LEN(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .verify_en(s_ven),
        .in_data(s_data), .in_valid(s_valid), .in_ready(s_ready),
        .prog_en(s_pen), .prog_in(s_pin), .prog_out(s_pout),
        .busy(s_busy), .done(s_done), .pass(s_pass), .crc(s_crc)
    );

    bitstream_loader #(.CHAIN_LEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .start(l_start), .verify_en(l_ven),
        .in_data(l_data), .in_valid(l_valid), .in_ready(l_ready),
        .prog_en(l_pen), .prog_in(l_pin), .prog_out(l_pout),
        .busy(l_busy), .done(l_done), .pass(l_pass), .crc(l_crc)
    );

    // Chain models: shift toward the far end whenever prog_en is high.
    logic [15:0] chain16 = '0;
    int          shifts16 = 0;
    bit          fault16 = 1'b0;
    int          fault_base16 = 0;
    logic [63:0] chain64 = '0;

    assign s_pout = chain16[15];
    assign l_pout = chain64[63];

    always @(posedge clk) begin
        logic [15:0] nxt;
        if (s_pen === 1'b1) begin
            nxt = {chain16[14:0], s_pin};
            if (fault16 && (shifts16 - fault_base16) == 15) nxt[7] = ~nxt[7];
            chain16  <= nxt;
            shifts16 <= shifts16 + 1;
        end
    end

    always @(posedge clk) begin
        if (l_pen === 1'b1) chain64 <= {chain64[62:0], l_pin};
    end

    function automatic logic [7:0] ref_crc(input logic [63:0] msg, input int nbytes);
        logic [7:0] c;
        c = 8'h00;
        for (int i = nbytes - 1; i >= 0; i--) begin
            c = c ^ msg[i*8 +: 8];
            for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one 16-bit load, optionally with a stall between bytes, a fault
    // injected after LOAD, or a stray start pulse mid-load.
    task automatic load16(input logic [15:0] msg, input bit ven, input int gap,
                          input bit fault, input bit poke,
                          output int pe_cnt, output int pe_hole, output int first_acc,
                          output int done_at, output logic busy_t1, output logic ready_t1,
                          output logic [7:0] crc_d, output logic pass_d, output logic busy_d);
        int k;
        int gap_left;
        bit armed;
        k = 0; gap_left = 0; armed = 1'b0;
        pe_cnt = 0; pe_hole = 0; first_acc = -1; done_at = -1;
        crc_d = 8'hxx; pass_d = 1'bx; busy_d = 1'bx;
        fault_base16 = shifts16;
        fault16 = fault;
        s_ven = ven;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        busy_t1 = s_busy;
        ready_t1 = s_ready;
        for (int c = 0; c < 200; c++) begin
            if (s_done === 1'b1) begin
                done_at = cyc; crc_d = s_crc; pass_d = s_pass; busy_d = s_busy;
                break;
            end
            if (s_pen === 1'b1) pe_cnt++;
            else if (first_acc >= 0 && cyc > first_acc && s_busy === 1'b1) pe_hole++;
            s_start = (poke && pe_cnt == 5) ? 1'b1 : 1'b0;
            s_ven   = (poke && pe_cnt == 5) ? ~ven : ven;
            if (k == 1 && armed && s_ready === 1'b1) begin
                gap_left = gap;
                armed = 1'b0;
            end
            if (gap_left > 0) begin
                s_valid = 1'b0;
                gap_left--;
            end else begin
                s_valid = (k < 2);
            end
            s_data = (k == 0) ? msg[15:8] : msg[7:0];
            if (s_valid && s_ready === 1'b1) begin
                if (k == 0) first_acc = cyc;
                k++;
                if (k == 1) armed = 1'b1;
            end
            step();
        end
        s_valid = 1'b0; s_start = 1'b0; s_ven = 1'b0; fault16 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_start = 0; s_ven = 0; s_valid = 1; s_data = 8'hFF;
        l_start = 0; l_ven = 0; l_valid = 1; l_data = 8'hFF;
        step(); step();
        rst_n = 1'b1;
        step();
        tests++;
        if ({s_pen, s_ready, s_busy, s_done, s_pass, s_crc, s_pin} !== 13'h0) begin
            fails++;
            $display("FAIL reset16: got pen/rdy/busy/done/pass/crc/pin=%b, want all 0",
                     {s_pen, s_ready, s_busy, s_done, s_pass, s_crc, s_pin});
        end
        tests++;
        if ({l_pen, l_ready, l_busy, l_done, l_pass, l_crc, l_pin} !== 13'h0) begin
            fails++;
            $display("FAIL reset64: got pen/rdy/busy/done/pass/crc/pin=%b, want all 0",
                     {l_pen, l_ready, l_busy, l_done, l_pass, l_crc, l_pin});
        end
        s_valid = 0; l_valid = 0;
    endtask

    task automatic test_load_no_verify();
        int pe, hole, fa, da;
        logic b1, r1, pd, bd;
        logic [7:0] cd;
        load16(16'hA53C, 1'b0, 0, 1'b0, 1'b0, pe, hole, fa, da, b1, r1, cd, pd, bd);
        tests++;
        if ({b1, r1} !== 2'b11) begin
            fails++; $display("FAIL start_latency: busy/in_ready at T+1 = %b, want 11", {b1, r1});
        end
        tests++;
        if (chain16 !== 16'hA53C) begin
            fails++; $display("FAIL nv_chain: got %h, want a53c", chain16);
        end
        tests++;
        if (cd !== ref_crc(64'hA53C, 2) || cd !== 8'hED) begin
            fails++; $display("FAIL nv_crc: got %h, want ed", cd);
        end
        tests++;
        if (pd !== 1'b1 || bd !== 1'b0) begin
            fails++; $display("FAIL nv_pass_busy: pass=%b busy=%b, want pass=1 busy=0", pd, bd);
        end
        tests++;
        if (da - fa !== 17) begin
            fails++; $display("FAIL nv_done_time: done %0d cycles after accept, want 17", da - fa);
        end
        tests++;
        if (pe !== 16 || hole !== 0) begin
            fails++; $display("FAIL nv_prog_en: %0d cycles, %0d holes, want 16, 0", pe, hole);
        end
        step();
        tests++;
        if (s_done !== 1'b0 || s_crc !== 8'hED || s_pass !== 1'b1) begin
            fails++;
            $display("FAIL nv_hold: done=%b crc=%h pass=%b, want 0 ed 1", s_done, s_crc, s_pass);
        end
    endtask

    task automatic test_load_verify();
        int pe, hole, fa, da;
        logic b1, r1, pd, bd;
        logic [7:0] cd;
        load16(16'hA53C, 1'b1, 0, 1'b0, 1'b0, pe, hole, fa, da, b1, r1, cd, pd, bd);
        tests++;
        if (chain16 !== 16'hA53C) begin
            fails++; $display("FAIL v_chain: got %h, want a53c", chain16);
        end
        tests++;
        if (pd !== 1'b1 || cd !== 8'hED) begin
            fails++; $display("FAIL v_result: pass=%b crc=%h, want 1 ed", pd, cd);
        end
        tests++;
        if (pe !== 32 || da - fa !== 33) begin
            fails++;
            $display("FAIL v_timing: prog_en=%0d done_delay=%0d, want 32, 33", pe, da - fa);
        end
    endtask

    task automatic test_fault();
        int pe, hole, fa, da;
        logic b1, r1, pd, bd;
        logic [7:0] cd;
        load16(16'hA53C, 1'b1, 0, 1'b1, 1'b0, pe, hole, fa, da, b1, r1, cd, pd, bd);
        tests++;
        if (pd !== 1'b0 || da < 0) begin
            fails++; $display("FAIL fault_pass: pass=%b done_at=%0d, want pass=0", pd, da);
        end
        tests++;
        if (cd !== 8'hED) begin
            fails++; $display("FAIL fault_crc: got %h, want ed", cd);
        end
    endtask

    task automatic test_stall();
        int pe, hole, fa, da;
        logic b1, r1, pd, bd;
        logic [7:0] cd;
        load16(16'hA53C, 1'b0, 5, 1'b0, 1'b0, pe, hole, fa, da, b1, r1, cd, pd, bd);
        tests++;
        if (hole !== 5 || pe !== 16) begin
            fails++; $display("FAIL stall_gap: holes=%0d prog_en=%0d, want 5, 16", hole, pe);
        end
        tests++;
        if (chain16 !== 16'hA53C || cd !== 8'hED) begin
            fails++; $display("FAIL stall_data: chain=%h crc=%h, want a53c ed", chain16, cd);
        end
        tests++;
        if (da - fa !== 22) begin
            fails++; $display("FAIL stall_done: done %0d after accept, want 22", da - fa);
        end
    endtask

    task automatic test_start_while_busy();
        int pe, hole, fa, da;
        logic b1, r1, pd, bd;
        logic [7:0] cd;
        load16(16'h5AC3, 1'b0, 0, 1'b0, 1'b1, pe, hole, fa, da, b1, r1, cd, pd, bd);
        tests++;
        if (pe !== 16 || da - fa !== 17) begin
            fails++;
            $display("FAIL busy_start_timing: prog_en=%0d done_delay=%0d, want 16, 17", pe, da - fa);
        end
        tests++;
        if (chain16 !== 16'h5AC3 || cd !== ref_crc(64'h5AC3, 2) || pd !== 1'b1) begin
            fails++;
            $display("FAIL busy_start_data: chain=%h crc=%h pass=%b, want 5ac3 %h 1",
                     chain16, cd, pd, ref_crc(64'h5AC3, 2));
        end
    endtask

    task automatic test_reset_mid_load();
        int n;
        int pe, hole, fa, da;
        logic b1, r1, pd, bd;
        logic [7:0] cd;
        n = 0;
        s_ven = 1'b0;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        s_data = 8'hA5;
        s_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (s_pen === 1'b1) n++;
            if (n == 5) break;
            if (s_valid && s_ready === 1'b1) begin
                step();
                s_valid = 1'b0;
            end else begin
                step();
            end
        end
        tests++;
        if (n !== 5) begin
            fails++; $display("FAIL rst_mid_reach: saw %0d bits, want 5", n);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({s_pen, s_ready, s_busy, s_done, s_pass, s_crc, s_pin} !== 13'h0) begin
            fails++;
            $display("FAIL rst_mid_outputs: got %b, want all 0",
                     {s_pen, s_ready, s_busy, s_done, s_pass, s_crc, s_pin});
        end
        step(); step();
        rst_n = 1'b1;
        step();
        load16(16'hA53C, 1'b0, 0, 1'b0, 1'b0, pe, hole, fa, da, b1, r1, cd, pd, bd);
        tests++;
        if (cd !== 8'hED || chain16 !== 16'hA53C || pd !== 1'b1) begin
            fails++;
            $display("FAIL rst_reload: crc=%h chain=%h pass=%b, want ed a53c 1", cd, chain16, pd);
        end
    endtask

    task automatic test_full_size();
        logic [63:0] msg;
        int k, pe, done_at;
        bit late_ready;
        for (int it = 0; it < 3; it++) begin
            msg = {$urandom, $urandom};
            k = 0; pe = 0; done_at = -1; late_ready = 1'b0;
            l_ven = 1'b1;
            l_start = 1'b1;
            step();
            l_start = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                if (l_done === 1'b1) begin
                    done_at = cyc;
                    break;
                end
                if (l_pen === 1'b1) pe++;
                if (k == 8 && l_ready !== 1'b0) late_ready = 1'b1;
                l_valid = (k < 8) && ($urandom_range(0, 2) != 0);
                if (k < 8) l_data = msg[8*(7-k) +: 8];
                if (l_valid && l_ready === 1'b1) k++;
                step();
            end
            l_valid = 1'b0;
            tests++;
            if (done_at < 0 || l_pass !== 1'b1) begin
                fails++; $display("FAIL full_done: done_at=%0d pass=%b, want done, pass=1", done_at, l_pass);
            end
            tests++;
            if (chain64 !== msg) begin
                fails++; $display("FAIL full_chain: got %h, want %h", chain64, msg);
            end
            tests++;
            if (l_crc !== ref_crc(msg, 8)) begin
                fails++; $display("FAIL full_crc: got %h, want %h", l_crc, ref_crc(msg, 8));
            end
            tests++;
            if (pe !== 128 || late_ready !== 1'b0) begin
                fails++;
                $display("FAIL full_flow: prog_en=%0d late_ready=%b, want 128, 0", pe, late_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_no_verify();
        test_load_verify();
        test_fault();
        test_stall();
        test_start_while_busy();
        test_reset_mid_load();
        test_full_size();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bitstream_loader.md
# bitstream_loader

Host-side driver for the serial configuration chain of the tiny FPGA fabric. Accepts the configuration bitstream as a byte stream with a valid/ready handshake and shifts it MSB-first into the chain via `prog_en`/`prog_in`. Optionally runs a non-destructive verify pass: it recirculates `prog_out` back into `prog_in` for one full chain length and compares a CRC-8 of the returned bits against the CRC-8 of the loaded bits. Sits between the host interface and the fabric top, in the same clock domain as `prog_clk`.

## Interface
- `CHAIN_LEN`, 64, total configuration bits in the chain; multiple of 8, ≥ 8.
- `clk` input 1, clock; also the fabric `prog_clk`.
- `rst_n` input 1, asynchronous active-low reset.
- `start` input 1, one-cycle pulse that begins a load; ignored unless IDLE or DONE.
- `verify_en` input 1, sampled with `start`; 1 = run VERIFY after LOAD.
- `in_data` input 8, bitstream byte; byte 0 first, MSB first.
- `in_valid` input 1, `in_data` valid.
- `in_ready` output 1, byte accepted when `in_valid && in_ready`.
- `prog_en` output 1, chain shift enable (registered).
- `prog_in` output 1, chain serial data in.
- `prog_out` input 1, chain serial data out.
- `busy` output 1, high in LOAD and VERIFY.
- `done` output 1, one-cycle pulse on entry to DONE.
- `pass` output 1, verify result; held until next accepted `start`.
- `crc` output 8, CRC-8 of loaded bits; held until next accepted `start`.

## Operation
- States: IDLE → LOAD on `start`; LOAD → VERIFY (`verify_en`=1) or DONE after CHAIN_LEN bits shifted; VERIFY → DONE after CHAIN_LEN cycles; DONE → LOAD on `start`, otherwise remains DONE.
- LOAD: 8-bit shifter plus bit counter (0..7) and a bit counter of width clog2(CHAIN_LEN+1).
  - `in_ready`=1 in LOAD when the shifter is empty or presenting its last bit, and fewer than CHAIN_LEN/8 bytes have been accepted.
  - Each shifted bit: `prog_en`=1, `prog_in`=shifter MSB; the CRC updates with that bit.
  - Shifter empty with no byte available: `prog_en`=0 (chain holds); stalls are unbounded.
- VERIFY: `prog_en`=1 for exactly CHAIN_LEN cycles; `prog_in` = `prog_out` combinationally, so the loop length equals CHAIN_LEN and the configuration is preserved. The verify CRC updates with each `prog_out` bit.
- CRC-8: polynomial 0x07, init 0x00, bit-serial, MSB-first, no reflection, no final XOR. Both CRCs are cleared on accepted `start`.
- On DONE entry:
  - `pass` = (verify CRC == load CRC) when verify ran.
  - `pass` = 1 when `verify_en` was 0.
- `start` while busy: ignored, no side effects.
- `in_valid` outside LOAD: ignored; `in_ready`=0.

## Timing
- Reset (async assert, sync deassert expected at top): state IDLE; `prog_en`, `in_ready`, `busy`, `done`, `pass` all 0; `crc` 0x00; `prog_in` 0.
- Reset mid-LOAD/VERIFY: `prog_en` drops immediately. Chain contents are undefined; the host must reload.
- `start` at cycle T → `busy`=1 and `in_ready`=1 at T+1.
- Byte accepted at cycle N → its MSB on `prog_in` with `prog_en`=1 at N+1, LSB at N+8.
- Back-to-back bytes (accepted on the last-bit cycle) produce no `prog_en` gap; full rate is 1 bit/cycle.
- Last LOAD bit at cycle L:
  - without verify: `done` pulses at L+1, `busy`=0 at L+1.
  - with verify: VERIFY bits occupy L+1..L+CHAIN_LEN, and `done` pulses at L+CHAIN_LEN+1.
- `crc` and `pass` are valid in the same cycle as `done`.

## Structure
- Shared package `fpga_cfg_pkg`:
  - state enum (IDLE, LOAD, VERIFY, DONE);
  - `CRC8_POLY` = 8'h07;
  - a function `crc8_step(crc, bit)`.
- One sub-module: `crc8_serial` (clear, enable, bit in, 8-bit value), instantiated twice (load, verify).
- Total RTL is approximately 150–250 lines.

## Test plan
- Bench includes a CHAIN_LEN-bit shift-register chain model driven by `prog_en`/`prog_in`.
- **Load without verify.** CHAIN_LEN=16, bytes 0xA5, 0x3C streamed with no gaps, `verify_en`=0 → chain holds 0xA53C (first bit at far end); `crc`=0xED, `pass`=1; `done` 17 cycles after first accept; `prog_en` high for exactly 16 cycles.
- **Load with verify.** Same stimulus with `verify_en`=1 → 16 extra `prog_en` cycles; chain still holds 0xA53C afterwards; `pass`=1, `crc`=0xED.
- **Fault injection.** Same as above, but the model flips one chain bit between LOAD and VERIFY → `pass`=0 at `done`.
- **Stalls.** `in_valid` deasserted for 5 cycles between bytes → `prog_en`=0 during the gap, final chain contents and `crc` identical to the no-gap case.
- **Start while busy / reset mid-load.**
  - `start` pulsed mid-LOAD → ignored, completes normally.
  - `rst_n` low after 5 bits → `prog_en`=0 immediately, all outputs at reset values.
  - A subsequent full load succeeds with `crc`=0xED.
- **Full-size load.** CHAIN_LEN=64, 8 random bytes with random `in_valid` gaps, `verify_en`=1 → chain matches bytes, `crc` matches bench reference CRC, `pass`=1, `in_ready` never high after the 8th accept.
